// File: rtl/pipe_pkg.sv
// Shared types for the generic valid/ready pipeline stage: occupancy, stage FSM state,
// counter word type and the per-stage payload structs packed into DATA_W by the datapath.
package pipe_pkg;

    typedef logic [1:0]  occ_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam word_t WORD_MAX = 32'hFFFF_FFFF;

    // IF/ID payload: the datapath packs this into a 64-bit stage.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } ifid_t;

    // Saturating increment shared by the performance counters.
    function automatic word_t sat_inc(input word_t value);
        sat_inc = (value == WORD_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_sat_ctr.sv
// 32-bit saturating event counter with synchronous clear; used for the stage
// performance counters when PIPE_STAGE_PERF_EN is defined.
module pipe_sat_ctr
    import pipe_pkg::*;
(
    input  logic  CLK,
    input  logic  clear,
    input  logic  inc,
    output word_t count
);

    // Count register: clear wins, otherwise saturating increment.
    always_ff @(posedge CLK) begin
        if (clear) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= sat_inc(count);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage with freeze/flush and optional 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output occ_t              occ
`ifdef PIPE_STAGE_PERF_EN
    ,
    output word_t             stall_cnt,
    output word_t             flush_cnt
`endif
);

    logic accept_s;
    logic consume_s;

    assign accept_s  = in_valid & in_ready;
    assign consume_s = out_valid & out_ready;

    generate
        if (SKID != 0) begin : gen_skid
            stage_state_t      state_r;
            stage_state_t      state_nxt_s;
            logic [DATA_W-1:0] main_r;
            logic [DATA_W-1:0] skid_r;
            logic [DATA_W-1:0] main_nxt_s;
            logic [DATA_W-1:0] skid_nxt_s;
            logic              rdy_r;

            // Flush forces ready so the squashed beat is drained; freeze blocks it.
            assign in_ready  = flush | (~freeze & rdy_r);
            assign out_valid = ~flush & ~freeze & (state_r != EMPTY);
            assign out_data  = main_r;
            assign occ       = occ_t'(state_r);

            // Next-state and entry movement; the skid entry only ever refills main.
            always_comb begin
                state_nxt_s = state_r;
                main_nxt_s  = main_r;
                skid_nxt_s  = skid_r;
                if (flush) begin
                    state_nxt_s = EMPTY;
                    main_nxt_s  = '0;
                    skid_nxt_s  = '0;
                end else if (freeze) begin
                    state_nxt_s = state_r;
                end else begin
                    case (state_r)
                        EMPTY: begin
                            if (accept_s) begin
                                state_nxt_s = ONE;
                                main_nxt_s  = in_data;
                            end else begin
                                state_nxt_s = EMPTY;
                            end
                        end
                        ONE: begin
                            if (accept_s && !consume_s) begin
                                state_nxt_s = FULL;
                                skid_nxt_s  = in_data;
                            end else if (consume_s && !accept_s) begin
                                state_nxt_s = EMPTY;
                            end else if (accept_s && consume_s) begin
                                state_nxt_s = ONE;
                                main_nxt_s  = in_data;
                            end else begin
                                state_nxt_s = ONE;
                            end
                        end
                        FULL: begin
                            if (consume_s) begin
                                state_nxt_s = ONE;
                                main_nxt_s  = skid_r;
                            end else begin
                                state_nxt_s = FULL;
                            end
                        end
                        default: begin
                            state_nxt_s = EMPTY;
                            main_nxt_s  = '0;
                            skid_nxt_s  = '0;
                        end
                    endcase
                end
            end

            // State, entries and the registered ready derived from the next occupancy.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    state_r <= EMPTY;
                    main_r  <= '0;
                    skid_r  <= '0;
                    rdy_r   <= 1'b1;
                end else begin
                    state_r <= state_nxt_s;
                    main_r  <= main_nxt_s;
                    skid_r  <= skid_nxt_s;
                    rdy_r   <= (state_nxt_s != FULL);
                end
            end
        end else begin : gen_single
            logic              valid_r;
            logic [DATA_W-1:0] data_r;

            assign in_ready  = flush | (~freeze & (~valid_r | out_ready));
            assign out_valid = ~flush & ~freeze & valid_r;
            assign out_data  = data_r;
            assign occ       = {1'b0, valid_r};

            // Single entry: a new beat replaces a consumed one on the same edge.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_r <= 1'b0;
                    data_r  <= '0;
                end else if (flush) begin
                    valid_r <= 1'b0;
                    data_r  <= '0;
                end else if (freeze) begin
                    valid_r <= valid_r;
                    data_r  <= data_r;
                end else if (accept_s) begin
                    valid_r <= 1'b1;
                    data_r  <= in_data;
                end else if (consume_s) begin
                    valid_r <= 1'b0;
                    data_r  <= data_r;
                end else begin
                    valid_r <= valid_r;
                    data_r  <= data_r;
                end
            end
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc_s;

    assign stall_inc_s = (out_valid & ~out_ready) | (freeze & (occ != 2'd0));

    pipe_sat_ctr u_stall_ctr (
        .CLK   (CLK),
        .clear (RST),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    pipe_sat_ctr u_flush_ctr (
        .CLK   (CLK),
        .clear (RST),
        .inc   (flush),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: one skid instance and one single-entry instance.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    int          total = 0;
    int          bad = 0;

    logic        s1_flush = 1'b0, s1_freeze = 1'b0, s1_in_valid = 1'b0, s1_out_ready = 1'b0;
    logic        s1_in_ready, s1_out_valid;
    logic [63:0] s1_in_data = 64'd0, s1_out_data;
    occ_t        s1_occ;
    logic        s0_flush = 1'b0, s0_freeze = 1'b0, s0_in_valid = 1'b0, s0_out_ready = 1'b0;
    logic        s0_in_ready, s0_out_valid;
    logic [63:0] s0_in_data = 64'd0, s0_out_data;
    occ_t        s0_occ;
`ifdef PIPE_STAGE_PERF_EN
    word_t       s1_stall_cnt, s1_flush_cnt, s0_stall_cnt, s0_flush_cnt;
`endif

    always #5 CLK = ~CLK;

    pipe_stage_buf #(.DATA_W(64), .SKID(1)) u_skid (
        .CLK(CLK), .RST(RST), .flush(s1_flush), .freeze(s1_freeze),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
        .occ(s1_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(s1_stall_cnt), .flush_cnt(s1_flush_cnt)
`endif
    );

    pipe_stage_buf #(.DATA_W(64), .SKID(0)) u_single (
        .CLK(CLK), .RST(RST), .flush(s0_flush), .freeze(s0_freeze),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .occ(s0_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(s0_stall_cnt), .flush_cnt(s0_flush_cnt)
`endif
    );

    // Inputs change 1 time unit after the edge; checks happen 4 units later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        #4;
        total++; if (s1_occ !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", s1_occ); end
        total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", s1_out_valid); end
        total++; if (s1_out_data !== 64'd0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", s1_out_data); end
        total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", s1_in_ready); end
        total++; if (s0_in_ready !== 1'b1 || s0_out_valid !== 1'b0) begin bad++; $display("FAIL reset_single got=%b%b exp=10", s0_in_ready, s0_out_valid); end
        tick();
    endtask

    task automatic test_stream();
        s1_out_ready = 1'b1;
        s1_in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s1_in_data = 64'(k + 1);
            #4;
            total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, s1_in_ready); end
            if (k > 0) begin
                total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'(k)) begin bad++; $display("FAIL stream_out k=%0d got=%b/%0h exp=1/%0h", k, s1_out_valid, s1_out_data, k); end
                total++; if (s1_occ !== 2'd1) begin bad++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, s1_occ); end
            end
            tick();
        end
        s1_in_valid = 1'b0;
        #4;
        total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'd5) begin bad++; $display("FAIL stream_last got=%b/%0h exp=1/5", s1_out_valid, s1_out_data); end
        tick();
        #4;
        total++; if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d/%b exp=0/0", s1_occ, s1_out_valid); end
        tick();
    endtask

    task automatic test_skid();
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'hA;
        tick();
        s1_in_data = 64'hB;
        #4;
        total++; if (s1_in_ready !== 1'b1 || s1_out_data !== 64'hA) begin bad++; $display("FAIL skid_second got=%b/%0h exp=1/a", s1_in_ready, s1_out_data); end
        tick();
        s1_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #4;
            total++; if (s1_occ !== 2'd2 || s1_in_ready !== 1'b0) begin bad++; $display("FAIL skid_full k=%0d got=%0d/%b exp=2/0", k, s1_occ, s1_in_ready); end
            total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'hA) begin bad++; $display("FAIL skid_hold k=%0d got=%b/%0h exp=1/a", k, s1_out_valid, s1_out_data); end
            tick();
        end
        s1_out_ready = 1'b1;
        #4;
        total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'hA) begin bad++; $display("FAIL skid_pop_a got=%b/%0h exp=1/a", s1_out_valid, s1_out_data); end
        tick();
        #4;
        total++; if (s1_out_data !== 64'hB || s1_in_ready !== 1'b1 || s1_occ !== 2'd1) begin bad++; $display("FAIL skid_pop_b got=%0h/%b/%0d exp=b/1/1", s1_out_data, s1_in_ready, s1_occ); end
        tick();
        #4;
        total++; if (s1_occ !== 2'd0) begin bad++; $display("FAIL skid_empty got=%0d exp=0", s1_occ); end
        tick();
    endtask

    task automatic test_flush();
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'h1A; tick();
        s1_in_data   = 64'h1B; tick();
        s1_flush   = 1'b1;
        s1_in_data = 64'hC;
        #4;
        total++; if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0) begin bad++; $display("FAIL flush_cycle got=%b/%b exp=1/0", s1_in_ready, s1_out_valid); end
        tick();
        s1_flush     = 1'b0;
        s1_in_valid  = 1'b0;
        s1_out_ready = 1'b1;
        #4;
        total++; if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0 || s1_out_data !== 64'd0) begin bad++; $display("FAIL flush_after got=%0d/%b/%0h exp=0/0/0", s1_occ, s1_out_valid, s1_out_data); end
        tick();
        #4;
        total++; if (s1_out_valid !== 1'b0 || s1_in_ready !== 1'b1) begin bad++; $display("FAIL flush_no_c got=%b/%b exp=0/1", s1_out_valid, s1_in_ready); end
        tick();
    endtask

    task automatic test_freeze();
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'h5;
        tick();
        s1_freeze  = 1'b1;
        s1_in_data = 64'h6;
        for (int k = 0; k < 3; k++) begin
            #4;
            total++; if (s1_in_ready !== 1'b0 || s1_out_valid !== 1'b0) begin bad++; $display("FAIL freeze_block k=%0d got=%b/%b exp=0/0", k, s1_in_ready, s1_out_valid); end
            total++; if (s1_occ !== 2'd1 || s1_out_data !== 64'h5) begin bad++; $display("FAIL freeze_hold k=%0d got=%0d/%0h exp=1/5", k, s1_occ, s1_out_data); end
            tick();
        end
        s1_freeze    = 1'b0;
        s1_out_ready = 1'b1;
        #4;
        total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'h5 || s1_in_ready !== 1'b1) begin bad++; $display("FAIL freeze_release got=%b/%0h/%b exp=1/5/1", s1_out_valid, s1_out_data, s1_in_ready); end
        tick();
        s1_in_valid = 1'b0;
        #4;
        total++; if (s1_out_valid !== 1'b1 || s1_out_data !== 64'h6) begin bad++; $display("FAIL freeze_pending got=%b/%0h exp=1/6", s1_out_valid, s1_out_data); end
        tick();
        #4;
        total++; if (s1_occ !== 2'd0) begin bad++; $display("FAIL freeze_drain got=%0d exp=0", s1_occ); end
        tick();
    endtask

    task automatic test_single();
        s0_out_ready = 1'b0;
        s0_in_valid  = 1'b1;
        s0_in_data   = 64'h21;
        #4;
        total++; if (s0_in_ready !== 1'b1) begin bad++; $display("FAIL single_first got=%b exp=1", s0_in_ready); end
        tick();
        s0_in_data = 64'h22;
        #1;
        total++; if (s0_in_ready !== 1'b0 || s0_occ !== 2'd1) begin bad++; $display("FAIL single_blocked got=%b/%0d exp=0/1", s0_in_ready, s0_occ); end
        s0_out_ready = 1'b1;
        #1;
        total++; if (s0_in_ready !== 1'b1 || s0_out_data !== 64'h21) begin bad++; $display("FAIL single_comb_ready got=%b/%0h exp=1/21", s0_in_ready, s0_out_data); end
        tick();
        s0_in_valid = 1'b0;
        #4;
        total++; if (s0_out_valid !== 1'b1 || s0_out_data !== 64'h22 || s0_occ !== 2'd1) begin bad++; $display("FAIL single_no_bubble got=%b/%0h/%0d exp=1/22/1", s0_out_valid, s0_out_data, s0_occ); end
        tick();
        #4;
        total++; if (s0_occ !== 2'd0 || s0_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0d/%b exp=0/0", s0_occ, s0_out_valid); end
        tick();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        RST = 1'b1; tick();
        RST = 1'b0;
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'h77;
        tick();
        s1_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        s1_out_ready = 1'b1; tick();
        s1_flush = 1'b1; tick(); tick();
        s1_flush = 1'b0;
        #4;
        total++; if (s1_stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", s1_stall_cnt); end
        total++; if (s1_flush_cnt !== 32'd2) begin bad++; $display("FAIL perf_flush got=%0d exp=2", s1_flush_cnt); end
        tick();
        s1_out_ready = 1'b0;
        s1_in_valid  = 1'b1;
        s1_in_data   = 64'h88;
        tick();
        RST = 1'b1; tick();
        RST = 1'b0;
        s1_in_valid = 1'b0;
        #4;
        total++; if (s1_stall_cnt !== 32'd0 || s1_flush_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", s1_stall_cnt, s1_flush_cnt); end
        total++; if (s1_occ !== 2'd0 || s1_out_valid !== 1'b0) begin bad++; $display("FAIL perf_reset_occ got=%0d/%b exp=0/0", s1_occ, s1_out_valid); end
        tick();
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_freeze();
        test_single();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
